// File: rtl/mem_responder.sv
// Memory-side responder: services readM/writeM after a fixed latency, pulses
// inputReady/ackOutput for one cycle, then waits for the request to drop.
module mem_responder #(
   parameter int WORD_SIZE  = 16,
   parameter int ADDR_WIDTH = 8,
   parameter int LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  Reset_N,
   input  logic                  readM,
   input  logic                  writeM,
   input  logic [WORD_SIZE-1:0]  address,
   input  logic [WORD_SIZE-1:0]  data_in,
   output logic [WORD_SIZE-1:0]  data_out,
   output logic                  inputReady,
   output logic                  ackOutput,
   output logic                  busy,
   output logic                  req_err,
   output logic [WORD_SIZE-1:0]  num_reads,
   output logic [WORD_SIZE-1:0]  num_writes,
   input  logic                  dbg_we,
   input  logic [ADDR_WIDTH-1:0] dbg_addr,
   input  logic [WORD_SIZE-1:0]  dbg_wdata
);
   // state   | meaning
   // IDLE    | waiting for exactly one of readM/writeM; backdoor writes allowed
   // RD_WAIT | read accepted, counting down latency
   // WR_WAIT | write accepted, counting down latency
   // RELEASE | completion pulsed, waiting for readM=writeM=0
   typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RELEASE} state_t;

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_t                state;
   logic [3:0]            cnt;
   logic [ADDR_WIDTH-1:0] idx;
   logic [WORD_SIZE-1:0]  wdata;
   logic [WORD_SIZE-1:0]  mem [DEPTH];

   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [WORD_SIZE-1:0]  mem_wdata;

   // Upper address bits are deliberately ignored: indexing wraps.
   if (WORD_SIZE > ADDR_WIDTH) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^address[WORD_SIZE-1:ADDR_WIDTH];
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      if (state == WR_WAIT && cnt == 4'd0) begin
         mem_we    = 1'b1;
         mem_addr  = idx;
         mem_wdata = wdata;
      end else if (state == IDLE && !readM && !writeM && dbg_we) begin
         mem_we = 1'b1;
      end
   end

   // Storage is never cleared; a write landing on a reset edge is dropped.
   always_ff @(posedge clk) begin
      if (Reset_N && mem_we)
         mem[mem_addr] <= mem_wdata;
   end

   always_ff @(posedge clk) begin
      if (!Reset_N) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         idx        <= '0;
         wdata      <= '0;
         data_out   <= '0;
         inputReady <= 1'b0;
         ackOutput  <= 1'b0;
         busy       <= 1'b0;
         req_err    <= 1'b0;
         num_reads  <= '0;
         num_writes <= '0;
      end else begin
         inputReady <= 1'b0;
         ackOutput  <= 1'b0;
         case (state)
            IDLE: begin
               if (readM && writeM) begin
                  req_err <= 1'b1;
               end else if (readM) begin
                  idx   <= address[ADDR_WIDTH-1:0];
                  cnt   <= CNT_INIT;
                  state <= RD_WAIT;
                  busy  <= 1'b1;
               end else if (writeM) begin
                  idx   <= address[ADDR_WIDTH-1:0];
                  wdata <= data_in;
                  cnt   <= CNT_INIT;
                  state <= WR_WAIT;
                  busy  <= 1'b1;
               end
            end
            RD_WAIT: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  data_out   <= mem[idx];
                  inputReady <= 1'b1;
                  num_reads  <= num_reads + 1'b1;
                  state      <= RELEASE;
               end
            end
            WR_WAIT: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  ackOutput  <= 1'b1;
                  num_writes <= num_writes + 1'b1;
                  state      <= RELEASE;
               end
            end
            RELEASE: begin
               if (!readM && !writeM) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: vector table of reads/writes plus
// hand sequences for release handshake, conflict, reset-mid-write and wrap.
module tb_mem_responder;
   logic        clk = 1'b0;
   logic        Reset_N = 1'b0;
   logic        readM = 1'b0, writeM = 1'b0;
   logic [15:0] address = '0, data_in = '0;
   logic [15:0] data_out, num_reads, num_writes;
   logic        inputReady, ackOutput, busy, req_err;
   logic        dbg_we = 1'b0;
   logic [7:0]  dbg_addr = '0;
   logic [15:0] dbg_wdata = '0;

   // Narrow instance with LATENCY=1 so the counter wrap is reachable quickly.
   logic        w_readM = 1'b0;
   logic [7:0]  w_data_out, w_num_reads, w_num_writes;
   logic        w_inputReady, w_ackOutput, w_busy, w_req_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_responder #(.WORD_SIZE(16), .ADDR_WIDTH(8), .LATENCY(2)) dut (
      .clk(clk), .Reset_N(Reset_N), .readM(readM), .writeM(writeM),
      .address(address), .data_in(data_in), .data_out(data_out),
      .inputReady(inputReady), .ackOutput(ackOutput), .busy(busy),
      .req_err(req_err), .num_reads(num_reads), .num_writes(num_writes),
      .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata));

   mem_responder #(.WORD_SIZE(8), .ADDR_WIDTH(4), .LATENCY(1)) dut_w (
      .clk(clk), .Reset_N(Reset_N), .readM(w_readM), .writeM(1'b0),
      .address(8'h00), .data_in(8'h00), .data_out(w_data_out),
      .inputReady(w_inputReady), .ackOutput(w_ackOutput), .busy(w_busy),
      .req_err(w_req_err), .num_reads(w_num_reads), .num_writes(w_num_writes),
      .dbg_we(1'b0), .dbg_addr(4'h0), .dbg_wdata(8'h00));

   typedef struct {
      logic        is_wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_data;
      int          exp_reads;
      int          exp_writes;
   } vec_t;
   vec_t vecs [10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic backdoor(input logic [7:0] a, input logic [15:0] d);
      dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
      tick();
      dbg_we = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a, output logic [15:0] d, output int lat);
      readM = 1'b1; address = a;
      tick();
      lat = 0;
      while (!inputReady && lat < 20) begin tick(); lat++; end
      d = data_out;
      readM = 1'b0;
      tick();
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] wd, output int lat);
      writeM = 1'b1; address = a; data_in = wd;
      tick();
      lat = 0;
      while (!ackOutput && lat < 20) begin tick(); lat++; end
      writeM = 1'b0;
      tick();
   endtask

   initial begin
      logic [15:0] d;
      int lat;

      vecs[0] = '{1'b1, 16'h0005, 16'h1234, 16'hBEEF, 1, 1};
      vecs[1] = '{1'b0, 16'h0005, 16'h0000, 16'h1234, 2, 1};
      vecs[2] = '{1'b1, 16'h0105, 16'h5678, 16'h1234, 2, 2};
      vecs[3] = '{1'b0, 16'h0005, 16'h0000, 16'h5678, 3, 2};
      vecs[4] = '{1'b0, 16'hFF05, 16'h0000, 16'h5678, 4, 2};
      vecs[5] = '{1'b1, 16'h00FF, 16'hA5A5, 16'h5678, 4, 3};
      vecs[6] = '{1'b0, 16'h00FF, 16'h0000, 16'hA5A5, 5, 3};
      vecs[7] = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 6, 3};
      vecs[8] = '{1'b1, 16'h0000, 16'hFFFF, 16'hBEEF, 6, 4};
      vecs[9] = '{1'b0, 16'h0100, 16'h0000, 16'hFFFF, 7, 4};

      repeat (3) tick();
      check("rst data_out", 32'(data_out), 32'h0);
      check("rst pulses", {30'h0, inputReady, ackOutput}, 32'h0);
      check("rst busy/err", {30'h0, busy, req_err}, 32'h0);
      check("rst counts", {num_reads, num_writes}, 32'h0);
      Reset_N = 1'b1;
      tick();

      backdoor(8'h10, 16'hBEEF);
      backdoor(8'h03, 16'h0001);

      rd(16'h0010, d, lat);
      check("first rd latency", 32'(lat), 32'd2);
      check("first rd data", 32'(d), 32'hBEEF);
      check("first rd count", 32'(num_reads), 32'd1);
      check("first rd busy after drop", 32'(busy), 32'd0);
      check("first rd pulse cleared", 32'(inputReady), 32'd0);

      for (int i = 0; i < 10; i++) begin
         if (vecs[i].is_wr) begin
            wr(vecs[i].addr, vecs[i].wdata, lat);
            check($sformatf("vec%0d wr latency", i), 32'(lat), 32'd2);
         end else begin
            rd(vecs[i].addr, d, lat);
            check($sformatf("vec%0d rd latency", i), 32'(lat), 32'd2);
         end
         check($sformatf("vec%0d data_out", i), 32'(data_out), 32'(vecs[i].exp_data));
         check($sformatf("vec%0d num_reads", i), 32'(num_reads), 32'(vecs[i].exp_reads));
         check($sformatf("vec%0d num_writes", i), 32'(num_writes), 32'(vecs[i].exp_writes));
      end

      // Release handshake: request held after completion must not retrigger.
      readM = 1'b1; address = 16'h0010;
      tick();
      lat = 0;
      while (!inputReady && lat < 20) begin tick(); lat++; end
      check("hold rd latency", 32'(lat), 32'd2);
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("hold%0d no pulse", i), 32'(inputReady), 32'd0);
         check($sformatf("hold%0d busy", i), 32'(busy), 32'd1);
      end
      readM = 1'b0;
      tick();
      check("hold released busy", 32'(busy), 32'd0);
      check("hold num_reads", 32'(num_reads), 32'd8);

      // Conflict in IDLE.
      readM = 1'b1; writeM = 1'b1; address = 16'h0003; data_in = 16'h9999;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("conflict%0d req_err", i), 32'(req_err), 32'd1);
         check($sformatf("conflict%0d idle", i), {29'h0, busy, inputReady, ackOutput}, 32'h0);
      end
      readM = 1'b0; writeM = 1'b0;
      tick();
      wr(16'h0020, 16'h7777, lat);
      check("post-conflict wr latency", 32'(lat), 32'd2);
      check("req_err sticky", 32'(req_err), 32'd1);
      check("post-conflict num_writes", 32'(num_writes), 32'd5);
      rd(16'h0003, d, lat);
      check("conflict left mem[3]", 32'(d), 32'h0001);
      rd(16'h0020, d, lat);
      check("post-conflict rd", 32'(d), 32'h7777);

      // Backdoor attempts while a request is present or pending are ignored.
      readM = 1'b1; address = 16'h0010;
      dbg_we = 1'b1; dbg_addr = 8'h10; dbg_wdata = 16'h0000;
      tick();
      lat = 0;
      while (!inputReady && lat < 20) begin tick(); lat++; end
      check("dbg-busy rd data", 32'(data_out), 32'hBEEF);
      dbg_we = 1'b0; readM = 1'b0;
      tick();
      rd(16'h0010, d, lat);
      check("dbg ignored mem[0x10]", 32'(d), 32'hBEEF);

      // Reset one cycle after write acceptance.
      writeM = 1'b1; address = 16'h0003; data_in = 16'h00AA;
      tick();
      Reset_N = 1'b0;
      tick();
      writeM = 1'b0;
      check("midrst data_out", 32'(data_out), 32'h0);
      check("midrst flags", {28'h0, inputReady, ackOutput, busy, req_err}, 32'h0);
      check("midrst counts", {num_reads, num_writes}, 32'h0);
      tick();
      check("midrst no ack", 32'(ackOutput), 32'd0);
      Reset_N = 1'b1;
      tick();
      rd(16'h0003, d, lat);
      check("midrst mem[3] kept", 32'(d), 32'h0001);
      check("midrst num_writes", 32'(num_writes), 32'd0);
      check("midrst num_reads", 32'(num_reads), 32'd1);

      // Counter wrap on the narrow instance.
      begin
         int timeouts = 0;
         int first_lat = -1;
         for (int i = 0; i < 256; i++) begin
            w_readM = 1'b1;
            tick();
            lat = 0;
            while (!w_inputReady && lat < 10) begin tick(); lat++; end
            if (lat >= 10) timeouts++;
            if (i == 0) first_lat = lat;
            w_readM = 1'b0;
            tick();
            if (i == 254) check("wrap num_reads 255", 32'(w_num_reads), 32'd255);
         end
         check("wrap latency1", 32'(first_lat), 32'd1);
         check("wrap timeouts", 32'(timeouts), 32'd0);
         check("wrap num_reads 0", 32'(w_num_reads), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
